// File: rtl/stream_pkt_arbiter.sv
// stream_pkt_arbiter: merges two Avalon-ST packet sources onto one sink.
// Whole packets are granted one at a time (round-robin or fixed priority),
// with an Avalon-MM CSR slave for control, per-port SOP counters and status.
module stream_pkt_arbiter #(
   parameter int DATA_BYTES = 8
) (
   input  logic                                              clk,
   input  logic                                              reset_n,
   // source port 0
   input  logic [DATA_BYTES*8-1:0]                           in0_data,
   input  logic [((DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1)-1:0] in0_empty,
   input  logic                                              in0_valid,
   input  logic                                              in0_startofpacket,
   input  logic                                              in0_endofpacket,
   output logic                                              in0_ready,
   // source port 1
   input  logic [DATA_BYTES*8-1:0]                           in1_data,
   input  logic [((DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1)-1:0] in1_empty,
   input  logic                                              in1_valid,
   input  logic                                              in1_startofpacket,
   input  logic                                              in1_endofpacket,
   output logic                                              in1_ready,
   // merged sink
   output logic [DATA_BYTES*8-1:0]                           out_data,
   output logic [((DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1)-1:0] out_empty,
   output logic                                              out_valid,
   output logic                                              out_startofpacket,
   output logic                                              out_endofpacket,
   input  logic                                              out_ready,
   // CSR slave
   input  logic [1:0]                                        csr_address,
   input  logic                                              csr_read,
   input  logic                                              csr_write,
   input  logic [31:0]                                       csr_writedata,
   output logic [31:0]                                       csr_readdata,
   output logic                                              csr_readdatavalid,
   output logic                                              csr_waitrequest
);

   localparam int EW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PKT0   = 2'd1;
   localparam logic [1:0] ADDR_PKT1   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        last_grant_next;

   logic [2:0]  ctrl;
   logic [31:0] pkt0_count;
   logic [31:0] pkt1_count;
   logic        err;

   logic        eligible0;
   logic        eligible1;
   logic        drain0;
   logic        drain1;
   logic        drain_event;
   logic        csr_wr;
   logic        status_read;
   logic        sop_acc0;
   logic        sop_acc1;
   logic [31:0] rd_mux;
   logic        unused_wdata;

   // Only bits 2:0 of a CTRL write carry meaning; the rest is ignored.
   assign unused_wdata = ^csr_writedata[31:3];

   // A port may start a packet only when enabled and showing a SOP beat;
   // an enabled port showing a non-SOP beat in IDLE is a stray remnant.
   assign eligible0 = ctrl[0] & in0_valid & in0_startofpacket;
   assign eligible1 = ctrl[1] & in1_valid & in1_startofpacket;
   assign drain0    = ctrl[0] & in0_valid & ~in0_startofpacket;
   assign drain1    = ctrl[1] & in1_valid & ~in1_startofpacket;

   assign drain_event = reset_n & (state == IDLE) & (drain0 | drain1);

   // A simultaneous read and write performs the read only.
   assign csr_wr      = csr_write & ~csr_read;
   assign status_read = csr_read & (csr_address == ADDR_STATUS);

   assign sop_acc0 = in0_valid & in0_ready & in0_startofpacket;
   assign sop_acc1 = in1_valid & in1_ready & in1_startofpacket;

   assign csr_waitrequest = ~reset_n;

   // Next-state, arbitration and stream muxing; outputs held quiet in reset.
   always_comb begin
      state_next        = state;
      last_grant_next   = last_grant;
      out_data          = '0;
      out_empty         = '0;
      out_valid         = 1'b0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      in0_ready         = 1'b0;
      in1_ready         = 1'b0;

      case (state)
         IDLE: begin
            in0_ready = drain0;
            in1_ready = drain1;
            if (eligible0 && eligible1) begin
               if (ctrl[2] || last_grant) begin
                  state_next      = GRANT0;
                  last_grant_next = 1'b0;
               end else begin
                  state_next      = GRANT1;
                  last_grant_next = 1'b1;
               end
            end else if (eligible0) begin
               state_next      = GRANT0;
               last_grant_next = 1'b0;
            end else if (eligible1) begin
               state_next      = GRANT1;
               last_grant_next = 1'b1;
            end
         end

         GRANT0: begin
            out_data          = in0_data;
            out_empty         = in0_empty;
            out_valid         = in0_valid;
            out_startofpacket = in0_startofpacket;
            out_endofpacket   = in0_endofpacket;
            in0_ready         = out_ready;
            if (in0_valid && out_ready && in0_endofpacket) begin
               state_next = IDLE;
            end
         end

         GRANT1: begin
            out_data          = in1_data;
            out_empty         = in1_empty;
            out_valid         = in1_valid;
            out_startofpacket = in1_startofpacket;
            out_endofpacket   = in1_endofpacket;
            in1_ready         = out_ready;
            if (in1_valid && out_ready && in1_endofpacket) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (!reset_n) begin
         out_valid = 1'b0;
         in0_ready = 1'b0;
         in1_ready = 1'b0;
      end
   end

   // State register and last-granted port; port 0 wins first after reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   // CTRL register: port enables and fixed-priority select.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl <= 3'b011;
      end else if (csr_wr && csr_address == ADDR_CTRL) begin
         ctrl <= csr_writedata[2:0];
      end
   end

   // Port 0 SOP counter; a clearing write beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt0_count <= '0;
      end else if (csr_wr && csr_address == ADDR_PKT0) begin
         pkt0_count <= '0;
      end else if (sop_acc0) begin
         pkt0_count <= pkt0_count + 32'd1;
      end
   end

   // Port 1 SOP counter; a clearing write beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt1_count <= '0;
      end else if (csr_wr && csr_address == ADDR_PKT1) begin
         pkt1_count <= '0;
      end else if (sop_acc1) begin
         pkt1_count <= pkt1_count + 32'd1;
      end
   end

   // Sticky drain error; a fresh drain outranks the read-to-clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if (drain_event) begin
         err <= 1'b1;
      end else if (status_read) begin
         err <= 1'b0;
      end
   end

   // CSR read data selection.
   always_comb begin
      rd_mux = '0;
      case (csr_address)
         ADDR_CTRL:   rd_mux = {29'd0, ctrl};
         ADDR_PKT0:   rd_mux = pkt0_count;
         ADDR_PKT1:   rd_mux = pkt1_count;
         ADDR_STATUS: rd_mux = {28'd0, err, last_grant, state};
         default:     rd_mux = '0;
      endcase
   end

   // Registered read response with a fixed latency of one cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         csr_readdata      <= '0;
         csr_readdatavalid <= 1'b0;
      end else begin
         csr_readdatavalid <= csr_read;
         if (csr_read) begin
            csr_readdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// tb_stream_pkt_arbiter: scoreboard bench for the two-port packet arbiter.
module tb_stream_pkt_arbiter;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  empty;
      logic        sop;
      logic        eop;
   } beat_t;

   logic        clk;
   logic        reset_n;
   logic [63:0] in0_data, in1_data, out_data;
   logic [2:0]  in0_empty, in1_empty, out_empty;
   logic        in0_valid, in0_startofpacket, in0_endofpacket, in0_ready;
   logic        in1_valid, in1_startofpacket, in1_endofpacket, in1_ready;
   logic        out_valid, out_startofpacket, out_endofpacket, out_ready;
   logic [1:0]  csr_address;
   logic        csr_read, csr_write;
   logic [31:0] csr_writedata, csr_readdata;
   logic        csr_readdatavalid, csr_waitrequest;

   beat_t       q0[$];
   beat_t       q1[$];
   beat_t       expq[$];
   logic        take0, take1;
   logic        eopLast;
   logic        drained1;
   logic [31:0] expPkt0, expPkt1;
   int          vectors;
   int          miscompares;

   stream_pkt_arbiter #(.DATA_BYTES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .in0_data(in0_data), .in0_empty(in0_empty), .in0_valid(in0_valid),
      .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket),
      .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_empty(in1_empty), .in1_valid(in1_valid),
      .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket),
      .in1_ready(in1_ready),
      .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_ready(out_ready),
      .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
      .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside a bounded wait.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Count one comparison and report it if the values differ.
   task automatic checkOutput(input string tag, input logic [95:0] actual,
                              input logic [95:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue a packet on a source; the first expBeats beats are expected out.
   task automatic applyStimulus(input int port, input int nbeats, input int expBeats);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         b.data  = {$urandom(), $urandom()};
         b.sop   = (i == 0);
         b.eop   = (i == nbeats - 1);
         b.empty = b.eop ? 3'($urandom_range(0, 7)) : 3'd0;
         if (port == 0) q0.push_back(b);
         else           q1.push_back(b);
         if (i < expBeats) expq.push_back(b);
      end
      if (expBeats > 0) begin
         if (port == 0) expPkt0++;
         else           expPkt1++;
      end
   endtask

   task automatic csrWrite(input logic [1:0] addr, input logic [31:0] data);
      tick();
      csr_write     = 1'b1;
      csr_address   = addr;
      csr_writedata = data;
      tick();
      csr_write     = 1'b0;
   endtask

   task automatic csrRead(input logic [1:0] addr, input logic [31:0] expected,
                          input string tag);
      tick();
      csr_read    = 1'b1;
      csr_address = addr;
      tick();
      csr_read    = 1'b0;
      checkOutput("csr_rdv", csr_readdatavalid, 1'b1);
      checkOutput(tag, csr_readdata, expected);
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while ((expq.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) checkOutput("timeout", expq.size() + q0.size() + q1.size(), 0);
   endtask

   task automatic waitOutValid(input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) checkOutput("grant_timeout", out_valid, 1'b1);
   endtask

   // Source drivers: pop the beat accepted at this edge, present the next.
   initial begin
      in0_valid = 0; in0_data = 0; in0_empty = 0; in0_startofpacket = 0; in0_endofpacket = 0;
      in1_valid = 0; in1_data = 0; in1_empty = 0; in1_startofpacket = 0; in1_endofpacket = 0;
      forever begin
         tick();
         if (take0 && q0.size() > 0) void'(q0.pop_front());
         if (take1 && q1.size() > 0) void'(q1.pop_front());
         take0 = 1'b0;
         take1 = 1'b0;
         if (q0.size() > 0) begin
            {in0_data, in0_empty, in0_startofpacket, in0_endofpacket} = q0[0];
            in0_valid = 1'b1;
         end else begin
            in0_valid = 1'b0;
         end
         if (q1.size() > 0) begin
            {in1_data, in1_empty, in1_startofpacket, in1_endofpacket} = q1[0];
            in1_valid = 1'b1;
         end else begin
            in1_valid = 1'b0;
         end
      end
   end

   // Output monitor: scoreboard compare, exclusive readies and idle gap.
   always @(negedge clk) begin
      beat_t e;
      take0 = in0_valid && in0_ready;
      take1 = in1_valid && in1_ready;
      if (in1_valid && in1_ready && !in1_startofpacket && !out_valid) drained1 = 1'b1;
      if (eopLast) checkOutput("idle_gap", out_valid, 1'b0);
      if (out_valid) checkOutput("rdy_excl", in0_ready & in1_ready, 1'b0);
      eopLast = out_valid && out_ready && out_endofpacket;
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            checkOutput("spurious_beat", out_valid, 1'b0);
         end else begin
            e = expq.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_flags", {out_empty, out_startofpacket, out_endofpacket},
                        {e.empty, e.sop, e.eop});
         end
      end
   end

   initial begin
      vectors = 0; miscompares = 0;
      take0 = 0; take1 = 0; eopLast = 0; drained1 = 0;
      expPkt0 = 0; expPkt1 = 0;
      reset_n = 0; out_ready = 1;
      csr_address = 0; csr_read = 0; csr_write = 0; csr_writedata = 0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_waitreq", csr_waitrequest, 1'b1);
      checkOutput("rst_outs", {out_valid, in0_ready, in1_ready}, 3'b000);
      checkOutput("rst_rdv", {csr_readdatavalid, csr_readdata}, 33'd0);
      reset_n = 1;
      tick();
      checkOutput("waitreq", csr_waitrequest, 1'b0);
      csrRead(2'd0, 32'h3, "ctrl_rst");
      csrRead(2'd1, 32'h0, "pkt0_rst");
      csrRead(2'd2, 32'h0, "pkt1_rst");
      csrRead(2'd3, 32'h4, "status_rst");

      // Round-robin alternation with continuous traffic
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 3, 3);
         applyStimulus(1, 3, 3);
      end
      waitDone(200);
      csrRead(2'd1, expPkt0, "pkt0_rr");
      csrRead(2'd2, expPkt1, "pkt1_rr");

      // Fixed priority: port 0 always wins while requesting
      csrWrite(2'd0, 32'h7);
      csrRead(2'd0, 32'h7, "ctrl_fixed");
      csrWrite(2'd1, 32'h0);
      csrWrite(2'd2, 32'h0);
      expPkt0 = 0; expPkt1 = 0;
      tick();
      out_ready = 0;
      for (int i = 0; i < 3; i++) applyStimulus(0, 2, 2);
      for (int i = 0; i < 3; i++) applyStimulus(1, 2, 2);
      waitOutValid(20);
      csrRead(2'd3, 32'h1, "status_fixed");
      csrRead(2'd2, 32'h0, "pkt1_fixed");
      out_ready = 1;
      waitDone(200);
      csrRead(2'd1, expPkt0, "pkt0_fixed");
      csrRead(2'd2, expPkt1, "pkt1_fixed_end");
      csrWrite(2'd0, 32'hFFFF_FFFB);
      csrRead(2'd0, 32'h3, "ctrl_mask");

      // Backpressure toggling during a 4-beat packet
      applyStimulus(0, 4, 4);
      applyStimulus(1, 2, 2);
      begin
         int n = 0;
         while (expq.size() != 0 && n < 200) begin
            tick();
            out_ready = ~out_ready;
            n++;
         end
         if (n >= 200) checkOutput("toggle_timeout", expq.size(), 0);
      end
      tick();
      out_ready = 1;
      waitDone(50);

      // Non-SOP beat on port 1 in IDLE is drained and flagged
      drained1 = 0;
      begin
         beat_t b;
         b.data = 64'hDEAD_BEEF_0BAD_F00D; b.empty = 3'd0; b.sop = 1'b0; b.eop = 1'b0;
         q1.push_back(b);
      end
      waitDone(20);
      checkOutput("drain_rdy", drained1, 1'b1);
      csrRead(2'd3, 32'hC, "status_err");
      csrRead(2'd3, 32'h4, "status_err_clr");

      // PKT0 wrap via backdoor preload, then clear racing a SOP
      csrWrite(2'd1, 32'h0);
      csrRead(2'd1, 32'h0, "pkt0_clr");
      tick();
      dut.pkt0_count = 32'hFFFF_FFFF;
      expPkt0 = 32'hFFFF_FFFF;
      csrRead(2'd1, expPkt0, "pkt0_preload");
      applyStimulus(0, 1, 1);
      waitDone(20);
      csrRead(2'd1, expPkt0, "pkt0_wrap");
      tick();
      out_ready = 0;
      applyStimulus(0, 1, 1);
      waitOutValid(20);
      tick();
      out_ready = 1; csr_write = 1; csr_address = 2'd1; csr_writedata = 0;
      tick();
      csr_write = 0;
      expPkt0 = 0;
      waitDone(20);
      csrRead(2'd1, expPkt0, "pkt0_clr_race");

      // Reset pulse mid-packet abandons it; remnants are drained after
      tick();
      out_ready = 0;
      applyStimulus(0, 4, 2);
      waitOutValid(20);
      out_ready = 1;
      tick();
      tick();
      out_ready = 0;
      reset_n = 0;
      tick();
      checkOutput("mid_rst_waitreq", csr_waitrequest, 1'b1);
      checkOutput("mid_rst_outs", {out_valid, in0_ready, in1_ready, csr_readdatavalid}, 4'b0000);
      reset_n = 1;
      out_ready = 1;
      expPkt0 = 0; expPkt1 = 0;
      waitDone(20);
      csrRead(2'd3, 32'hC, "status_after_rst");
      csrRead(2'd0, 32'h3, "ctrl_after_rst");
      csrRead(2'd1, 32'h0, "pkt0_after_rst");
      csrRead(2'd2, 32'h0, "pkt1_after_rst");
      applyStimulus(0, 2, 2);
      applyStimulus(1, 2, 2);
      waitDone(50);
      csrRead(2'd1, expPkt0, "pkt0_final");
      csrRead(2'd2, expPkt1, "pkt1_final");
      checkOutput("expq_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stream_pkt_arbiter.md
STREAM_PKT_ARBITER -- requirements
Module: stream_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 8, giving the bytes per beat on all stream ports.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports in0_data and in1_data, input, DATA_BYTES*8 bits: source 0/1 beat data.
REQ-005 The block SHALL have ports in0_empty and in1_empty, input, $clog2(DATA_BYTES) bits: empty bytes on the EOP beat.
REQ-006 The block SHALL have ports in0_valid, in0_startofpacket, in0_endofpacket (and in1_ equivalents), input, 1 bit each: Avalon-ST qualifiers.
REQ-007 The block SHALL have ports in0_ready and in1_ready, output, 1 bit: source 0/1 ready, readyLatency 0.
REQ-008 The block SHALL have ports out_data, out_empty, out_valid, out_startofpacket, out_endofpacket, output, widths as inputs: the merged stream.
REQ-009 The block SHALL have port out_ready, input, 1 bit: sink ready, readyLatency 0.
REQ-010 The block SHALL have ports csr_address (input, 2 bits), csr_read (input, 1), csr_write (input, 1), csr_writedata (input, 32): Avalon-MM slave command.
REQ-011 The block SHALL have ports csr_readdata (output, 32), csr_readdatavalid (output, 1), csr_waitrequest (output, 1): Avalon-MM slave response.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT0, GRANT1; "beat accepted" on port n means inN_valid & inN_ready.
REQ-013 In IDLE, a port is eligible when it is enabled and presents valid with startofpacket; with no eligible port, the FSM SHALL stay in IDLE.
REQ-014 With CTRL.fixed=0, arbitration SHALL be round-robin: if both ports are eligible, grant the port not granted last (port 0 after reset); with CTRL.fixed=1, port 0 SHALL always win.
REQ-015 The grant SHALL take effect the cycle after the decision (one-cycle arbitration latency); in IDLE, out_valid=0 and inN_ready=0 except per REQ-019.
REQ-016 In GRANTn, out_* SHALL equal inN_* combinationally, inN_ready = out_ready, and the other port's ready SHALL be 0.
REQ-017 In GRANTn, an accepted beat with endofpacket SHALL return the FSM to IDLE; a single-beat packet (SOP and EOP) SHALL do the same; minimum one idle cycle between packets.
REQ-018 Clearing a port's enable mid-packet SHALL NOT end the grant; the packet completes, and the port is ineligible from the next IDLE.
REQ-019 In IDLE, an enabled port presenting valid without startofpacket SHALL be drained: its ready is asserted, the beat is discarded, and STATUS.err is set.
REQ-020 CSR address 0 CTRL [R/W]: bit0 enable port 0, bit1 enable port 1, bit2 fixed priority; bits 31-3 read 0; reset value 0x3.
REQ-021 CSR addresses 1 and 2, PKT0 and PKT1 [R, write clears]: 32-bit counts of SOP beats accepted from port 0/1; wrap 0xFFFFFFFF->0; clear wins over a simultaneous increment.
REQ-022 CSR address 3 STATUS [RO]: bits1-0 state (0 IDLE, 1 GRANT0, 2 GRANT1), bit2 last-granted port, bit3 err (sticky, cleared by a read of address 3); a new error in the clearing cycle keeps err=1.
REQ-023 csr_waitrequest SHALL be 0 except during reset; read latency SHALL be fixed at 1 (csr_readdatavalid high exactly the cycle after csr_read); a simultaneous read and write SHALL perform the read only.

Reset
REQ-024 While reset_n=0 at a clock edge, the FSM SHALL go to IDLE and the last-granted port to 1 (so port 0 wins first), PKT0=PKT1=0, CTRL=0x3, err=0, and csr_readdatavalid=0.
REQ-025 During and after reset, out_valid, in0_ready and in1_ready SHALL be 0 until a grant; csr_waitrequest SHALL be 1 while reset_n=0; csr_readdata SHALL reset to 0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; on the following IDLE, non-SOP remnants are drained per REQ-019.

Verification
REQ-027 Both ports present 3-beat packets continuously with out_ready=1 -> output alternates p0,p1,p0,p1 with 1 idle cycle each; PKT0 and PKT1 both increment.
REQ-028 Write CTRL=0x7 with both ports always requesting -> only port 0 is granted; PKT1 stays 0; STATUS reads 0x1 while a packet is in flight.
REQ-029 out_ready toggles 1,0,1,0 during a 4-beat packet -> no beat is lost or duplicated, the other port's ready stays 0, and the grant is held until the EOP beat.
REQ-030 Port 1 presents a valid non-SOP beat in IDLE -> in1_ready=1 that cycle and the beat is absent from the output; STATUS bit3=1, and a second read returns bit3=0.
REQ-031 Preload PKT0 near wrap: write-clear, then 2^32-1 SOPs (forced via backdoor) plus 1 more -> reads 0; a write to address 1 coincident with a SOP -> reads 0.
REQ-032 Assert reset_n=0 for 1 cycle mid-packet -> next cycle state is IDLE, counts are 0, CTRL=0x3, and the following SOP on port 0 is granted first.
